// File: rtl/lelbc_iter_core_if.sv
`default_nettype none
// ============================================================================
// Module   : lelbc_iter_core_if
// Purpose  : request/response bundle for lelbc_iter_core. The master side
//            issues a block request and takes the result; the slave side is
//            the cipher core.
// Revision : 1.0 - initial release
// ============================================================================
interface lelbc_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [63:0]  din;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  dout;

  modport master (
    output in_valid, mode, din, key, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, mode, din, key, out_ready,
    output in_ready, out_valid, dout
  );
endinterface
`default_nettype wire

// File: rtl/lelbc_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : lelbc_iter_core
// Purpose  : iterative 64-bit block / 128-bit key cipher, one round or one
//            key-schedule step per clock. Bit 0 of every block/key is the
//            MSB, so block bits [0:31] live in [63:32] and key bits [0:31]
//            live in [127:96].
// Options  : define LELBC_KEY_CACHE_EN to remember the last decrypt master
//            key together with its final round key, so a repeated decrypt
//            with the same key skips key preparation.
// Revision : 1.0 - initial release
// ============================================================================
module lelbc_iter_core #(
  parameter int ROUNDS = 25,
  parameter int ROT_K  = 13
) (
  input wire               clk,
  input wire               rst,
  lelbc_iter_core_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEYPREP = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [4:0] c_last_rnd = 5'(ROUNDS - 1);
  localparam logic [4:0] c_last_kp  = 5'(ROUNDS - 2);

  state_t       state_q, state_d;
  logic [63:0]  data_q,  data_d;
  logic [127:0] key_q,   key_d;
  logic [4:0]   cnt_q,   cnt_d;
  logic         mode_q,  mode_d;
`ifdef LELBC_KEY_CACHE_EN
  logic [127:0] ckey_q,   ckey_d;
  logic [127:0] cklast_q, cklast_d;
  logic         cvld_q,   cvld_d;
`endif

  // 4-bit S-box; it is an involution so one table serves both directions.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'hE;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hA;
      4'h4: sbox4 = 4'h4;  4'h5: sbox4 = 4'hF;  4'h6: sbox4 = 4'h2;  4'h7: sbox4 = 4'h7;
      4'h8: sbox4 = 4'h9;  4'h9: sbox4 = 4'h8;  4'hA: sbox4 = 4'h3;  4'hB: sbox4 = 4'hB;
      4'hC: sbox4 = 4'h0;  4'hD: sbox4 = 4'hD;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h5;
    endcase
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[n*4 +: 4] = sbox4(x[n*4 +: 4]);
    return y;
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  // Forward key step: rotate left, then fold the step index into the low bits.
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [4:0] idx);
    logic [127:0] t;
    t = (k << ROT_K) | (k >> (128 - ROT_K));
    t[4:0] = t[4:0] ^ idx;
    return t;
  endfunction

  // Inverse key step: remove the step index, then rotate right.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [4:0] idx);
    logic [127:0] t;
    t = k;
    t[4:0] = t[4:0] ^ idx;
    return (t >> ROT_K) | (t << (128 - ROT_K));
  endfunction

  function automatic logic [63:0] enc_round(input logic [63:0] x, input logic [127:0] k);
    logic [31:0] sa, sb;
    logic [63:0] ab;
    sb = x[31:0] ^ k[127:96];
    sa = x[63:32] ^ rotl5(sb);
    ab = sbox64({sa, sb});
    return {ab[63:32] ^ k[95:64], ab[31:0] ^ rotl5(ab[63:32])};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] x, input logic [127:0] k);
    logic [31:0] a, b;
    logic [63:0] s;
    a = x[63:32] ^ k[95:64];
    b = rotl5(a) ^ x[31:0];
    s = sbox64({a, b});
    return {s[63:32] ^ rotl5(s[31:0]), s[31:0] ^ k[127:96]};
  endfunction

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
`ifdef LELBC_KEY_CACHE_EN
    ckey_d   = ckey_q;
    cklast_d = cklast_q;
    cvld_d   = cvld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.din;
          key_d   = bus.key;
          mode_d  = bus.mode;
          cnt_d   = '0;
          state_d = S_RUN;
          // Decrypt needs the last round key first; with one round K_0 is it.
          if (bus.mode && (ROUNDS > 1)) begin
`ifdef LELBC_KEY_CACHE_EN
            if (cvld_q && (ckey_q == bus.key)) begin
              key_d = cklast_q;
            end else begin
              ckey_d  = bus.key;
              cvld_d  = 1'b0;
              state_d = S_KEYPREP;
            end
`else
            state_d = S_KEYPREP;
`endif
          end
        end
      end
      S_KEYPREP: begin
        key_d = key_fwd(key_q, cnt_q + 5'd1);
        if (cnt_q == c_last_kp) begin
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef LELBC_KEY_CACHE_EN
          cklast_d = key_fwd(key_q, cnt_q + 5'd1);
          cvld_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RUN: begin
        if (mode_q) begin
          // Decrypt holds K_j with j = ROUNDS-1-cnt; step back to K_{j-1}.
          data_d = dec_round(data_q, key_q);
          key_d  = key_inv(key_q, c_last_rnd - cnt_q);
        end else begin
          data_d = enc_round(data_q, key_q);
          key_d  = key_fwd(key_q, cnt_q + 5'd1);
        end
        if (cnt_q == c_last_rnd) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
`ifdef LELBC_KEY_CACHE_EN
      ckey_q   <= '0;
      cklast_q <= '0;
      cvld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
`ifdef LELBC_KEY_CACHE_EN
      ckey_q   <= ckey_d;
      cklast_q <= cklast_d;
      cvld_q   <= cvld_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.dout      = data_q;

endmodule
`default_nettype wire

// File: doc/lelbc_iter_core.md
LELBC_ITER_CORE -- requirements
Module: lelbc_iter_core

Interface
REQ-001 Parameter ROUNDS, default 25, number of cipher rounds; legal range 1..31.
REQ-002 Parameter ROT_K, default 13, key-register rotation per round; legal range 1..127.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  core can accept a request.
REQ-007 mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-008 din  input  64  [0:63] block, bit 0 MSB; sampled on accept.
REQ-009 key  input  128  [0:127] master key K_0; sampled on accept.
REQ-010 out_valid  output  1  dout holds a finished result.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 dout  output  64  [0:63] result block.

Function
REQ-013 Sbox S SHALL be C,E,6,A,4,F,2,7,9,8,3,B,0,D,1,5 (index 0..F); S is an involution, so the same table SHALL serve both directions.
REQ-014 Key schedule: K_{i+1} = rotl(K_i, ROT_K), then bits [123:127] ^= (i+1) mod 32; inverse step: undo XOR with (i+1), then rotr by ROT_K.
REQ-015 Decrypt round D(x,k): L=x[0:31], R=x[32:63]; a=L^k[32:63]; b=rotl(a,5)^R; (sa,sb)=S per nibble on a||b; out = (sa^rotl(sb,5)) || (sb^k[0:31]).
REQ-016 Encrypt round E(x,k) SHALL be exact inverse of D: sb=R^k[0:31]; sa=L^rotl(sb,5); a||b=S(sa||sb); out = (a^k[32:63]) || (b^rotl(a,5)).
REQ-017 Encrypt SHALL apply E with K_0..K_{ROUNDS-1} in order; decrypt SHALL apply D with K_{ROUNDS-1}..K_0 in order.
REQ-018 FSM states IDLE, KEYPREP, RUN, DONE; one round or one key step per cycle.
REQ-019 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-020 IDLE->RUN on accept with mode=0, or mode=1 with ROUNDS=1; IDLE->KEYPREP on accept with mode=1 and ROUNDS>1.
REQ-021 KEYPREP SHALL run ROUNDS-1 forward key steps, then go to RUN holding K_{ROUNDS-1}.
REQ-022 RUN SHALL execute ROUNDS rounds, stepping key forward (encrypt) or inverse (decrypt), then go to DONE.
REQ-023 Latency accept->out_valid: encrypt ROUNDS cycles; decrypt 2*ROUNDS-1 cycles.
REQ-024 DONE: out_valid=1, dout stable; DONE->IDLE on out_ready; out_ready outside DONE ignored.
REQ-025 Round counter 5 bits, no wrap within legal ROUNDS; in_valid while busy SHALL be ignored, not queued.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1, out_valid=0, dout=0, counter=0, data and key registers=0 immediately, including mid-KEYPREP/RUN/DONE; an in-flight result is discarded.
REQ-027 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro LELBC_KEY_CACHE_EN defined: core SHALL store last master key and its K_{ROUNDS-1} with a valid flag (cleared by reset); decrypt accept with key equal to cached key SHALL skip KEYPREP (latency ROUNDS); encrypt never touches cache.
REQ-029 Macro undefined: no cache logic; every decrypt SHALL pass KEYPREP.

Verification
REQ-030 ROUNDS=1, decrypt, din=0, key=0 -> dout=64'h55555555CCCCCCCC after 1 cycle.
REQ-031 ROUNDS=25, encrypt din=64'h0123456789ABCDEF key=128'h000102030405060708090A0B0C0D0E0F, then decrypt result with same key -> original din; latencies 25 and 49 cycles.
REQ-032 Hold out_ready=0 for 10 cycles in DONE -> out_valid and dout stable, in_ready=0, new in_valid ignored.
REQ-033 Assert rst mid-RUN (cycle 7) -> same cycle out_valid=0, in_ready=1, dout=0; next request completes correctly.
REQ-034 LELBC_KEY_CACHE_EN: two back-to-back decrypts, same key -> latencies 49 then 25; third with different key -> 49.
REQ-035 1000 random {mode,din,key} round-trips at ROUNDS in {1,2,31} -> all recover plaintext.
